// File: rtl/rns_pkg.sv
// Shared definitions for the RNS modular-subtract scheduler: default residue width,
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package rns_pkg;

    localparam int unsigned RNS_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StCorr = 2'd2,
        StDone = 2'd3
    } rns_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rns_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, cyclic.
module rns_rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   grant_next,
    output logic [IDW-1:0] id_next,
    output logic           any_req
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant_next = '0;
        id_next    = '0;
        any_req    = |req;
        idx        = 0;
        found      = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                found           = 1'b1;
                grant_next[idx] = 1'b1;
                id_next         = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rns_modsub_scheduler.sv
// Shares one W-bit modular subtractor between N requesters with round-robin arbitration.
// Optional operand-range checking on the err output is enabled by RNS_MODSUB_ERRCHK_EN.
module rns_modsub_scheduler
    import rns_pkg::*;
#(
    parameter int unsigned W   = RNS_W,
    parameter int unsigned N   = 4,
    localparam int unsigned IDW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    input  logic [N*W-1:0] m_in,
    output logic [N-1:0]   grant,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic [IDW-1:0] res_id,
    input  logic           res_ready,
    output logic           err
);

    rns_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [W:0]     diff;

    logic [N-1:0]   grant_next;
    logic [IDW-1:0] id_next;
    logic           any_req;
    logic [W-1:0]   a_sel, b_sel, m_sel;

    rns_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .grant_next (grant_next),
        .id_next    (id_next),
        .any_req    (any_req)
    );

    assign a_sel = a_in[id_next*W +: W];
    assign b_sel = b_in[id_next*W +: W];
    assign m_sel = m_in[id_next*W +: W];

    // Two's-complement subtract; a clear carry-out means a < b.
    assign diff = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};

`ifdef RNS_MODSUB_ERRCHK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        grant_d     = '0;
`ifdef RNS_MODSUB_ERRCHK_EN
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    m_d     = m_sel;
                    id_d    = id_next;
                    grant_d = grant_next;
                    state_d = StSub;
`ifdef RNS_MODSUB_ERRCHK_EN
                    err_d   = (a_sel >= m_sel) | (b_sel >= m_sel) | (m_sel < W'(2));
`endif
                end
            end
            StSub: begin
                res_data_d = diff[W-1:0];
                if (!diff[W]) begin
                    state_d = StCorr;
                end else begin
                    state_d     = StDone;
                    res_valid_d = 1'b1;
                end
            end
            StCorr: begin
                // Wraps mod 2^W back into [1, m-1] for in-range operands.
                res_data_d  = res_data_q + m_q;
                res_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
                    state_d     = StIdle;
`ifdef RNS_MODSUB_ERRCHK_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            grant_q     <= '0;
`ifdef RNS_MODSUB_ERRCHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            grant_q     <= grant_d;
`ifdef RNS_MODSUB_ERRCHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = id_q;
`ifdef RNS_MODSUB_ERRCHK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_rns_modsub_scheduler.sv
// Scoreboard bench for rns_modsub_scheduler: stimulus pushes expected results at grant,
// a negedge monitor pops and compares on each result handshake.
module tb_rns_modsub_scheduler;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in, m_in;
    logic [N-1:0]   grant;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_ready;
    logic           err;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [W-1:0] rm [N];
    logic [N-1:0] hold;

    typedef struct {
        int id;
        int data;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   gseq[$];
    int   model_ptr;
    int   n_checks;
    int   n_fail;
    exp_t mon_e;

    rns_modsub_scheduler #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .m_in      (m_in),
        .grant     (grant),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a_in = '0;
        b_in = '0;
        m_in = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = ra[i];
            b_in[i*W +: W] = rb[i];
            m_in[i*W +: W] = rm[i];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // (a - b) mod m, with the mod 2^W wrap the caller gets for out-of-range operands.
    function automatic int model_sub(input int a, input int b, input int m);
        int d;
        d = a - b;
        if (d < 0) d = (((d + m) % 16) + 16) % 16;
        return d;
    endfunction

    function automatic int model_err(input int a, input int b, input int m);
`ifdef RNS_MODSUB_ERRCHK_EN
        return (a >= m || b >= m || m < 2) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_ops(input int i);
        int m;
        m     = $urandom_range(15, 2);
        rm[i] = W'(m);
        ra[i] = W'($urandom_range(m - 1, 0));
        rb[i] = W'($urandom_range(m - 1, 0));
    endtask

    task automatic set_req(input int i, input int a, input int b, input int m);
        ra[i]  = W'(a);
        rb[i]  = W'(b);
        rm[i]  = W'(m);
        req[i] = 1'b1;
    endtask

    task automatic handle_grant();
        int   id;
        exp_t e;
        if (grant != '0) begin
            id = rr_pick(req, model_ptr);
            check("grant_rr", int'(grant), (id < 0) ? 0 : (1 << id));
            check("grant_no_pending", exp_q.size(), 0);
            if (id >= 0) begin
                e.id   = id;
                e.data = model_sub(ra[id], rb[id], rm[id]);
                e.err  = model_err(ra[id], rb[id], rm[id]);
                exp_q.push_back(e);
                gseq.push_back(id);
                if (hold[id]) rand_ops(id);
                else req[id] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        handle_grant();
    endtask

    task automatic drain();
        int ok;
        ok        = 0;
        hold      = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            step();
            if (req == '0 && exp_q.size() == 0 && !res_valid && grant == '0) ok = 1;
        end
        check("drain_done", ok, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_single(input int i, input int a, input int b, input int m,
                              input int exp_lat);
        int n;
        set_req(i, a, b, m);
        step();
        check("single_grant", int'(grant), 1 << i);
        step();
        n = 1;
        check("grant_pulse", int'(grant), 0);
        while (!res_valid && n < 10) begin
            step();
            n++;
        end
        check("latency", n, exp_lat);
        step();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_ptr = 0;
        end else if (res_valid && res_ready) begin
            check("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("res_data", int'(res_data), mon_e.data);
                check("res_id", int'(res_id), mon_e.id);
                check("err", int'(err), mon_e.err);
                model_ptr = (mon_e.id + 1) % N;
            end
        end
    end

    initial begin
        int exp_order[5];
        int n;
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        rst       = 1'b1;
        req       = '0;
        hold      = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rm[i] = 4'd2;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_data", int'(res_data), 0);
        check("rst_id", int'(res_id), 0);
        check("rst_err", int'(err), 0);
        rst       = 1'b0;
        res_ready = 1'b1;

        run_single(0, 9, 4, 13, 1);
        run_single(2, 3, 7, 13, 2);
        run_single(1, 6, 6, 7, 1);
        drain();

        // All four held: strict rotation from pointer 0.
        pulse_reset();
        gseq.delete();
        for (int i = 0; i < N; i++) rand_ops(i);
        hold = '1;
        req  = '1;
        for (int c = 0; c < 60 && gseq.size() < 5; c++) step();
        hold = '0;
        exp_order = '{0, 1, 2, 3, 0};
        check("t4_grant_count", int'(gseq.size() >= 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < gseq.size()) check("t4_order", gseq[k], exp_order[k]);
        end
        drain();

        // Back-pressure: result held, other requests ignored.
        res_ready = 1'b0;
        set_req(3, 2, 9, 11);
        n = 0;
        do begin
            step();
            n++;
        end while (!res_valid && n < 20);
        check("t5_valid_reached", int'(res_valid), 1);
        set_req(0, 5, 1, 7);
        repeat (10) begin
            step();
            check("t5_hold_valid", int'(res_valid), 1);
            check("t5_no_grant", int'(grant), 0);
            check("t5_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                check("t5_data_stable", int'(res_data), exp_q[0].data);
                check("t5_id_stable", int'(res_id), exp_q[0].id);
            end
        end
        res_ready = 1'b1;
        step();
        check("t5_released", int'(res_valid), 0);
        drain();

        // Reset while in the correction phase.
        set_req(1, 3, 7, 13);
        step();
        step();
        rst = 1'b1;
        #1;
        check("t6_grant", int'(grant), 0);
        check("t6_valid", int'(res_valid), 0);
        check("t6_data", int'(res_data), 0);
        check("t6_id", int'(res_id), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ra[0] = 4'd8; rb[0] = 4'd3; rm[0] = 4'd11;
        ra[2] = 4'd1; rb[2] = 4'd4; rm[2] = 4'd5;
        req = 4'b0101;
        step();
        check("t6_next_grant", int'(grant), 1);
        drain();

`ifdef RNS_MODSUB_ERRCHK_EN
        set_req(2, 14, 2, 13);
        n = 0;
        do begin
            step();
            n++;
        end while (!res_valid && n < 20);
        check("t7_err_set", int'(err), 1);
        step();
        check("t7_err_clear", int'(err), 0);
        drain();
`endif

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4) == 0) begin
                    rand_ops(i);
                    req[i] = 1'b1;
                end
                hold[i] = (($urandom % 4) == 0);
            end
            res_ready = (($urandom % 10) < 7);
            step();
        end
        drain();
        check("queue_empty_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
